// File: rtl/mem_access_unit_if.sv
// Memory bus bundle between the MEM-stage access unit (master) and the memory system (slave).
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: stalls the pipeline while a single bus transaction runs,
// builds byte enables / replicated store data, and formats load data for MEM/WB.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead_MEM,
  input  logic                  MemWrite_MEM,
  input  logic [1:0]            MemSize_MEM,
  input  logic                  MemSign_MEM,
  input  logic [31:0]           ALUres_MEM,
  input  logic [31:0]           WrData_MEM,
  output logic [31:0]           MemRd_MEM,
  output logic                  stall,
  output logic                  AddrErr,
  output logic                  BusErr,
  mem_access_unit_if.master     bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rdata;
  logic             r_buserr;

  logic w_acc;
  logic w_aligned;
  logic w_valid;

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b10:   byte_en = 4'b0001 << a;
      2'b01:   byte_en = a[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_rep(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b10:   lane_rep = {4{d[7:0]}};
      2'b01:   lane_rep = {2{d[15:0]}};
      default: lane_rep = d;
    endcase
  endfunction

  // Right-align the addressed lane, then sign- or zero-extend it.
  function automatic logic [31:0] fmt_load(input logic [1:0] sz, input logic [1:0] a,
                                           input logic sgn, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (sz)
      2'b10:   fmt_load = {{24{sgn & b[7]}}, b};
      2'b01:   fmt_load = {{16{sgn & h[15]}}, h};
      default: fmt_load = d;
    endcase
  endfunction

  assign w_acc = MemRead_MEM | MemWrite_MEM;

  always_comb begin
    w_aligned = 1'b0;
    case (MemSize_MEM)
      2'b00:   w_aligned = (ALUres_MEM[1:0] == 2'b00);
      2'b01:   w_aligned = ~ALUres_MEM[0];
      2'b10:   w_aligned = 1'b1;
      default: w_aligned = 1'b0;
    endcase
  end

  assign w_valid = w_acc & w_aligned;

  // stall and AddrErr must react in the same cycle as the request, so they stay combinational.
  assign stall     = ~rst & (((r_state == S_IDLE) & w_valid) | (r_state == S_REQ));
  assign AddrErr   = ~rst & (r_state == S_IDLE) & w_acc & ~w_valid;
  assign BusErr    = r_buserr;
  assign MemRd_MEM = (r_state == S_DONE) ? r_rdata : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_rdata       <= 32'd0;
      r_buserr      <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_be    <= 4'd0;
      bus.bus_addr  <= 32'd0;
      bus.bus_wdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_buserr <= 1'b0;
          if (w_valid) begin
            r_state       <= S_REQ;
            r_cnt         <= '0;
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= MemWrite_MEM;
            bus.bus_addr  <= {ALUres_MEM[31:2], 2'b00};
            bus.bus_be    <= byte_en(MemSize_MEM, ALUres_MEM[1:0]);
            bus.bus_wdata <= lane_rep(MemSize_MEM, WrData_MEM);
          end
        end
        S_REQ: begin
          // An ack on the final allowed cycle still counts as a completion.
          if (bus.bus_ack) begin
            r_state     <= S_DONE;
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
            bus.bus_be  <= 4'd0;
            r_rdata     <= bus.bus_we ? 32'd0
                         : fmt_load(MemSize_MEM, ALUres_MEM[1:0], MemSign_MEM, bus.bus_rdata);
          end else if (r_cnt == CNT_LAST) begin
            r_state     <= S_DONE;
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
            bus.bus_be  <= 4'd0;
            r_rdata     <= 32'd0;
            r_buserr    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_cnt    <= '0;
          r_buserr <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a behavioural model of byte lanes,
// load formatting, stall length and timeout.
module tb_mem_access_unit;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_MEM, MemWrite_MEM, MemSign_MEM;
  logic [1:0]  MemSize_MEM;
  logic [31:0] ALUres_MEM, WrData_MEM;
  logic [31:0] MemRd_MEM;
  logic        stall, AddrErr, BusErr;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit_if bus_if();

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
    .MemSize_MEM(MemSize_MEM), .MemSign_MEM(MemSign_MEM),
    .ALUres_MEM(ALUres_MEM), .WrData_MEM(WrData_MEM),
    .MemRd_MEM(MemRd_MEM), .stall(stall), .AddrErr(AddrErr), .BusErr(BusErr),
    .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    MemRead_MEM = 0; MemWrite_MEM = 0; MemSize_MEM = 2'b00; MemSign_MEM = 0;
    ALUres_MEM = 0; WrData_MEM = 0; bus_if.bus_ack = 0; bus_if.bus_rdata = 0;
  endtask

  // Called just after a rising edge with the unit in IDLE; returns just after the edge
  // that ends the access (DONE -> IDLE, or the single AddrErr cycle).
  task automatic drive_access(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rdat, input int ack_at, input string nm);
    bit          acc, ok, tmo;
    int          nreq, nstall, off;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd, e_addr, v;

    acc = rd | wr;
    off = int'(addr % 4);
    case (sz)
      2'b00:   ok = (off == 0);
      2'b01:   ok = (off % 2 == 0);
      2'b10:   ok = 1;
      default: ok = 0;
    endcase
    ok     = ok && acc;
    tmo    = !(ack_at >= 1 && ack_at <= TMO);
    nreq   = tmo ? TMO : ack_at;
    e_addr = addr - (addr % 4);
    case (sz)
      2'b10: begin
        e_be = 4'(1 << off);
        e_wd = {24'd0, wd[7:0]} * 32'h0101_0101;
        v    = (rdat >> (8 * off)) % 256;
        if (sg && v >= 128) v = v + 32'hFFFF_FF00;
      end
      2'b01: begin
        e_be = 4'(3 << (off / 2 * 2));
        e_wd = {16'd0, wd[15:0]} * 32'h0001_0001;
        v    = (rdat >> (8 * (off / 2 * 2))) % 65536;
        if (sg && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: begin
        e_be = 4'hF; e_wd = wd; v = rdat;
      end
    endcase
    e_rd = (wr || tmo) ? 32'd0 : v;

    MemRead_MEM = rd; MemWrite_MEM = wr; MemSize_MEM = sz; MemSign_MEM = sg;
    ALUres_MEM = addr; WrData_MEM = wd; bus_if.bus_ack = 0;

    @(negedge clk);
    n_checks++;
    if (stall !== ok || AddrErr !== (acc && !ok) || bus_if.bus_req !== 1'b0 ||
        MemRd_MEM !== 32'd0 || BusErr !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: stall=%b AddrErr=%b req=%b rd=%h buserr=%b, expected stall=%b AddrErr=%b req=0 rd=0 buserr=0",
               nm, stall, AddrErr, bus_if.bus_req, MemRd_MEM, BusErr, ok, acc && !ok);
    end
    if (!ok) begin
      @(posedge clk); #1;
      return;
    end
    nstall = 1;

    @(posedge clk); #1;
    for (int k = 1; k <= TMO; k++) begin
      bus_if.bus_ack   = (k == ack_at);
      bus_if.bus_rdata = (k == ack_at) ? rdat : $urandom;
      @(negedge clk);
      if (stall === 1'b1) nstall++;
      n_checks++;
      if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== e_addr || bus_if.bus_we !== wr ||
          bus_if.bus_be !== e_be || (wr && bus_if.bus_wdata !== e_wd) || MemRd_MEM !== 32'd0) begin
        n_fail++;
        $display("FAIL %s req%0d: req=%b addr=%h we=%b be=%b wdata=%h rd=%h, expected req=1 addr=%h we=%b be=%b wdata=%h rd=0",
                 nm, k, bus_if.bus_req, bus_if.bus_addr, bus_if.bus_we, bus_if.bus_be,
                 bus_if.bus_wdata, MemRd_MEM, e_addr, wr, e_be, e_wd);
      end
      @(posedge clk); #1;
      bus_if.bus_ack = 0;
      if (k == ack_at) break;
    end

    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || bus_if.bus_req !== 1'b0 || MemRd_MEM !== e_rd || BusErr !== tmo ||
        AddrErr !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done: stall=%b req=%b rd=%h buserr=%b AddrErr=%b, expected stall=0 req=0 rd=%h buserr=%b AddrErr=0",
               nm, stall, bus_if.bus_req, MemRd_MEM, BusErr, AddrErr, e_rd, tmo);
    end
    n_checks++;
    if (nstall != nreq + 1) begin
      n_fail++;
      $display("FAIL %s stall_len: got %0d cycles, expected %0d", nm, nstall, nreq + 1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (MemRd_MEM !== 32'd0 || BusErr !== 1'b0 || bus_if.bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: rd=%h buserr=%b req=%b, expected all 0",
               nm, MemRd_MEM, BusErr, bus_if.bus_req);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    MemRead_MEM = 1; ALUres_MEM = 32'h3001;
    #12;
    n_checks++;
    if (stall !== 0 || AddrErr !== 0 || BusErr !== 0 || MemRd_MEM !== 0 || bus_if.bus_req !== 0 ||
        bus_if.bus_we !== 0 || bus_if.bus_be !== 0 || bus_if.bus_addr !== 0 || bus_if.bus_wdata !== 0) begin
      n_fail++;
      $display("FAIL reset_state: stall=%b AddrErr=%b BusErr=%b rd=%h req=%b we=%b be=%b addr=%h wdata=%h, expected all 0",
               stall, AddrErr, BusErr, MemRd_MEM, bus_if.bus_req, bus_if.bus_we, bus_if.bus_be,
               bus_if.bus_addr, bus_if.bus_wdata);
    end
    clear_inputs();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_lb_signed();
    drive_access(1, 0, 2'b10, 1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1, "lb_signed");
  endtask

  task automatic test_sh();
    drive_access(0, 1, 2'b01, 0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 3, "sh");
  endtask

  task automatic test_misaligned();
    drive_access(1, 0, 2'b00, 0, 32'h0000_3001, 32'h0, 32'h0, 1, "lw_misaligned");
    drive_access(1, 0, 2'b11, 0, 32'h0000_3000, 32'h0, 32'h0, 1, "illegal_size");
    drive_access(1, 0, 2'b01, 1, 32'h0000_3003, 32'h0, 32'h0, 1, "lh_misaligned");
    clear_inputs();
  endtask

  task automatic test_timeout();
    drive_access(1, 0, 2'b00, 0, 32'h0000_5000, 32'h0, 32'hDEAD_BEEF, 0, "lw_timeout");
    drive_access(1, 0, 2'b00, 0, 32'h0000_5004, 32'h0, 32'h1357_9BDF, TMO, "lw_ack_last");
  endtask

  task automatic test_reset_in_req();
    MemRead_MEM = 1; MemSize_MEM = 2'b00; ALUres_MEM = 32'h0000_6000;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1;
    #1;
    n_checks++;
    if (stall !== 0 || AddrErr !== 0 || BusErr !== 0 || MemRd_MEM !== 0 || bus_if.bus_req !== 0 ||
        bus_if.bus_we !== 0 || bus_if.bus_be !== 0 || bus_if.bus_addr !== 0 || bus_if.bus_wdata !== 0) begin
      n_fail++;
      $display("FAIL reset_in_req: stall=%b req=%b be=%b addr=%h rd=%h, expected all 0",
               stall, bus_if.bus_req, bus_if.bus_be, bus_if.bus_addr, MemRd_MEM);
    end
    clear_inputs();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    bus_if.bus_ack = 1; bus_if.bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_checks++;
    if (stall !== 0 || bus_if.bus_req !== 0) begin
      n_fail++;
      $display("FAIL late_ack_idle: stall=%b req=%b, expected 0 0", stall, bus_if.bus_req);
    end
    @(posedge clk); #1;
    bus_if.bus_ack = 0;
    @(negedge clk);
    n_checks++;
    if (MemRd_MEM !== 0 || BusErr !== 0 || stall !== 0) begin
      n_fail++;
      $display("FAIL late_ack_ignored: rd=%h buserr=%b stall=%b, expected 0 0 0", MemRd_MEM, BusErr, stall);
    end
    @(posedge clk); #1;
    drive_access(1, 0, 2'b00, 0, 32'h0000_6004, 32'h0, 32'hCAFE_F00D, 2, "lw_after_reset");
  endtask

  task automatic test_back_to_back();
    drive_access(1, 0, 2'b01, 0, 32'h0000_4000, 32'h0, 32'h1234_9ABC, 1, "lhu");
    drive_access(1, 0, 2'b00, 0, 32'h0000_4004, 32'h0, 32'h0BAD_CAFE, 2, "lw_second");
    drive_access(1, 1, 2'b10, 0, 32'h0000_4005, 32'h0000_00A5, 32'h0, 1, "rd_wr_is_write");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = (a[1:0] & 2'(($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00));
      drive_access(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom, $urandom, $urandom_range(0, TMO + 1), "random");
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_lb_signed();
    test_sh();
    test_misaligned();
    test_timeout();
    test_reset_in_req();
    test_back_to_back();
    test_random();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
